// File: rtl/frog_button_ctrl.sv
// -----------------------------------------------------------------------------
// frog_button_ctrl
// Input-side conditioner for the two-player frog game. Each of the four raw
// push-buttons is synchronised, debounced and turned into one-cycle step
// pulses. Holding a button can auto-repeat the pulse. A go/back pair of the
// same player pressed together cancels both pulses for that cycle.
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-high reset
//   go_1_raw    player-1 forward button (async, active-high)
//   go_2_raw    player-2 forward button
//   back_1_raw  player-1 backward button
//   back_2_raw  player-2 backward button
//   go_1        one-cycle step pulse, player-1 forward
//   go_2        one-cycle step pulse, player-2 forward
//   back_1      one-cycle step pulse, player-1 backward
//   back_2      one-cycle step pulse, player-2 backward
//   held        debounced levels {back_2, back_1, go_2, go_1}
// -----------------------------------------------------------------------------
module frog_button_ctrl #(
    parameter int DEB_CYCLES    = 500000,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter bit REPEAT_EN     = 1'b1,
    parameter int CNT_W         = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go_1_raw,
    input  logic       go_2_raw,
    input  logic       back_1_raw,
    input  logic       back_2_raw,
    output logic       go_1,
    output logic       go_2,
    output logic       back_1,
    output logic       back_2,
    output logic [3:0] held
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    // Channel order matches the held vector: {back_2, back_1, go_2, go_1}.
    logic [3:0] raw_in;
    logic [3:0] s0_q;
    logic [3:0] s1_q;
    logic [3:0] raw_pulse;
    logic [3:0] pulse_d;
    logic [3:0] pulse_q;

    assign raw_in = {back_2_raw, back_1_raw, go_2_raw, go_1_raw};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_q <= '0;
            s1_q <= '0;
        end else begin
            s0_q <= raw_in;
            s1_q <= s0_q;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_ch
        logic             lvl_q;
        logic             lvl_d;
        logic [CNT_W-1:0] deb_cnt_q;
        logic [CNT_W-1:0] deb_cnt_d;
        state_t           state_q;
        state_t           state_d;
        logic [CNT_W-1:0] hold_cnt_q;
        logic [CNT_W-1:0] hold_cnt_d;
        logic             pulse_c;

        // Debounce: any cycle back at the current level restarts the count.
        always_comb begin
            lvl_d     = lvl_q;
            deb_cnt_d = '0;
            if (s1_q[i] != lvl_q) begin
                if (deb_cnt_q == DEB_LAST) begin
                    lvl_d = s1_q[i];
                end else begin
                    deb_cnt_d = deb_cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lvl_q     <= 1'b0;
                deb_cnt_q <= '0;
            end else begin
                lvl_q     <= lvl_d;
                deb_cnt_q <= deb_cnt_d;
            end
        end

        // Press FSM: state register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q    <= IDLE;
                hold_cnt_q <= '0;
            end else begin
                state_q    <= state_d;
                hold_cnt_q <= hold_cnt_d;
            end
        end

        // Press FSM: next state. IDLE is only ever entered with the level
        // low, so a high level seen in IDLE is always a fresh press.
        always_comb begin
            state_d    = state_q;
            hold_cnt_d = hold_cnt_q;
            case (state_q)
                IDLE: begin
                    if (lvl_q) begin
                        state_d    = HOLD;
                        hold_cnt_d = '0;
                    end
                end
                HOLD: begin
                    if (!lvl_q) begin
                        state_d    = IDLE;
                        hold_cnt_d = '0;
                    end else if (REPEAT_EN) begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            state_d    = REPEAT;
                            hold_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_cnt_q + CNT_W'(1);
                        end
                    end
                    // Without repeat the counter is frozen so it never wraps.
                end
                REPEAT: begin
                    if (!lvl_q) begin
                        state_d    = IDLE;
                        hold_cnt_d = '0;
                    end else if (hold_cnt_q == REP_LAST) begin
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                end
            endcase
        end

        // Press FSM: output (pre-filter step request).
        always_comb begin
            pulse_c = 1'b0;
            case (state_q)
                IDLE:    pulse_c = lvl_q;
                HOLD:    pulse_c = lvl_q && REPEAT_EN && (hold_cnt_q == HOLD_LAST);
                REPEAT:  pulse_c = lvl_q && (hold_cnt_q == REP_LAST);
                default: pulse_c = 1'b0;
            endcase
        end

        assign raw_pulse[i] = pulse_c;
        assign held[i]      = lvl_q;
    end

    // A player asking to go both ways in the same cycle gets neither step.
    always_comb begin
        pulse_d    = '0;
        pulse_d[0] = raw_pulse[0] & ~raw_pulse[2];
        pulse_d[2] = raw_pulse[2] & ~raw_pulse[0];
        pulse_d[1] = raw_pulse[1] & ~raw_pulse[3];
        pulse_d[3] = raw_pulse[3] & ~raw_pulse[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_q <= '0;
        end else begin
            pulse_q <= pulse_d;
        end
    end

    assign go_1   = pulse_q[0];
    assign go_2   = pulse_q[1];
    assign back_1 = pulse_q[2];
    assign back_2 = pulse_q[3];

endmodule

// File: tb/tb_frog_button_ctrl.sv
module tb_frog_button_ctrl;

    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int REP  = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       go_1_raw, go_2_raw, back_1_raw, back_2_raw;
    logic       go_1_a, go_2_a, back_1_a, back_2_a;
    logic [3:0] held_a;
    logic       go_1_b, go_2_b, back_1_b, back_2_b;
    logic [3:0] held_b;

    always #5 clk = ~clk;

    frog_button_ctrl #(
        .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP),
        .REPEAT_EN(1'b1), .CNT_W(26)
    ) dut_rep (
        .clk(clk), .rst(rst),
        .go_1_raw(go_1_raw), .go_2_raw(go_2_raw),
        .back_1_raw(back_1_raw), .back_2_raw(back_2_raw),
        .go_1(go_1_a), .go_2(go_2_a), .back_1(back_1_a), .back_2(back_2_a),
        .held(held_a)
    );

    frog_button_ctrl #(
        .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP),
        .REPEAT_EN(1'b0), .CNT_W(26)
    ) dut_norep (
        .clk(clk), .rst(rst),
        .go_1_raw(go_1_raw), .go_2_raw(go_2_raw),
        .back_1_raw(back_1_raw), .back_2_raw(back_2_raw),
        .go_1(go_1_b), .go_2(go_2_b), .back_1(back_1_b), .back_2(back_2_b),
        .held(held_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Every button sample since the last reset is kept. A level flips when the
    // DEB samples seen two edges ago and before all disagree with it. Pulses
    // are placed by elapsed time since the debounced press began.
    bit        samp [4][4096];
    int        n = 0;
    bit        mlvl [2][4];
    int        rise_at [2][4];
    bit  [3:0] exp_p [2];
    bit  [3:0] exp_h [2];
    bit  [3:0] m_raw;
    bit  [3:0] m_rp;
    int        m_dt;

    function automatic bit window_differs(input int c, input int e, input bit cur);
        int idx;
        bit v;
        for (int k = 0; k < DEB; k++) begin
            idx = e - 2 - k;
            v   = (idx < 0) ? 1'b0 : samp[c][idx];
            if (v == cur) return 1'b0;
        end
        return 1'b1;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                n = 0;
                for (int d = 0; d < 2; d++) begin
                    for (int c = 0; c < 4; c++) begin
                        mlvl[d][c]    = 1'b0;
                        rise_at[d][c] = 0;
                    end
                    exp_p[d] = '0;
                    exp_h[d] = '0;
                end
            end else begin
                m_raw = {back_2_raw, back_1_raw, go_2_raw, go_1_raw};
                for (int c = 0; c < 4; c++) samp[c][n] = m_raw[c];
                for (int d = 0; d < 2; d++) begin
                    for (int c = 0; c < 4; c++) begin
                        m_rp[c] = 1'b0;
                        if (mlvl[d][c]) begin
                            m_dt = n - 1 - rise_at[d][c];
                            if (m_dt == 0) m_rp[c] = 1'b1;
                            else if (d == 0 && m_dt >= HOLD && ((m_dt - HOLD) % REP) == 0)
                                m_rp[c] = 1'b1;
                        end
                        if (window_differs(c, n, mlvl[d][c])) begin
                            mlvl[d][c] = ~mlvl[d][c];
                            if (mlvl[d][c]) rise_at[d][c] = n;
                        end
                        exp_h[d][c] = mlvl[d][c];
                    end
                    exp_p[d] = {m_rp[3] & ~m_rp[1], m_rp[2] & ~m_rp[0],
                                m_rp[1] & ~m_rp[3], m_rp[0] & ~m_rp[2]};
                end
                if (n < 4095) n++;
            end
        end
    end

    // Cycle-by-cycle compare against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("cmp_pulses_rep", {28'd0, back_2_a, back_1_a, go_2_a, go_1_a}, {28'd0, exp_p[0]});
            check("cmp_held_rep", {28'd0, held_a}, {28'd0, exp_h[0]});
            check("cmp_pulses_norep", {28'd0, back_2_b, back_1_b, go_2_b, go_1_b}, {28'd0, exp_p[1]});
            check("cmp_held_norep", {28'd0, held_b}, {28'd0, exp_h[1]});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic idle(input int cycles);
        go_1_raw = 0; go_2_raw = 0; back_1_raw = 0; back_2_raw = 0;
        repeat (cycles) @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    // Inputs for edge k are set before the loop waits; the negedge after edge k
    // then shows what the DUT registered at k.
    int q[$];
    int qb[$];
    int cnt, hcnt, t1, t2;
    int rep_lit [6] = '{6, 16, 21, 26, 31, 36};

    initial begin
        rst = 1; go_1_raw = 1; go_2_raw = 1; back_1_raw = 1; back_2_raw = 1;
        repeat (3) @(negedge clk);
        check("reset_pulses", {28'd0, back_2_a, back_1_a, go_2_a, go_1_a}, 0);
        check("reset_held", {28'd0, held_a}, 0);

        // Reset release with go_1 still held.
        rst = 0; go_2_raw = 0; back_1_raw = 0; back_2_raw = 0;
        cnt = 0; t1 = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (go_1_a) begin cnt++; if (t1 < 0) t1 = k; end
            if (k == 6) check("reset_held_after", {28'd0, held_a}, 4'b0001);
        end
        check("reset_first_pulse_t", t1, 6);
        check("reset_pulse_count", cnt, 1);
        idle(12);

        // Glitch of 3 cycles on go_2.
        cnt = 0; hcnt = 0;
        for (int k = 0; k < 14; k++) begin
            go_2_raw = (k < 3);
            @(negedge clk);
            if (go_2_a) cnt++;
            if (held_a != 0) hcnt++;
        end
        check("glitch_pulses", cnt, 0);
        check("glitch_held_cycles", hcnt, 0);
        idle(12);

        // Hold-repeat on back_1 for 40 cycles.
        q.delete(); qb.delete();
        for (int k = 0; k < 56; k++) begin
            back_1_raw = (k < 40);
            @(negedge clk);
            if (back_1_a) q.push_back(k);
            if (back_1_b) qb.push_back(k);
        end
        for (int i = 0; i < 6; i++)
            check($sformatf("repeat_pulse_%0d", i), (i < q.size()) ? q[i] : -1, rep_lit[i]);
        check("repeat_none_late", ((q.size() > 0) ? q[q.size()-1] : 999) < 46, 1);
        check("norepeat_count", qb.size(), 1);
        check("norepeat_t", (qb.size() > 0) ? qb[0] : -1, 6);
        idle(12);

        // Same-player conflict: go_1 and back_1 together.
        cnt = 0;
        for (int k = 0; k < 24; k++) begin
            go_1_raw = (k < 15); back_1_raw = (k < 15);
            @(negedge clk);
            if (go_1_a || back_1_a) cnt++;
        end
        check("conflict_p1_pulses", cnt, 0);
        idle(12);

        // Cross-player presses are independent.
        t1 = -1; t2 = -1;
        for (int k = 0; k < 14; k++) begin
            go_1_raw = (k < 8); go_2_raw = (k < 8);
            @(negedge clk);
            if (go_1_a && t1 < 0) t1 = k;
            if (go_2_a && t2 < 0) t2 = k;
        end
        check("cross_go_1_t", t1, 6);
        check("cross_go_2_t", t2, 6);
        idle(12);

        // Bounce: toggle every cycle for 10 cycles, then stable high.
        cnt = 0; t1 = -1;
        for (int k = 0; k < 24; k++) begin
            go_1_raw = (k >= 10) ? 1'b1 : ((k % 2) == 0);
            @(negedge clk);
            if (go_1_a) begin cnt++; if (t1 < 0) t1 = k; end
        end
        check("bounce_count", cnt, 1);
        check("bounce_t", t1, 16);
        idle(12);

        // Reset while back_2 is auto-repeating.
        q.delete();
        for (int k = 0; k < 19; k++) begin
            back_2_raw = 1;
            @(negedge clk);
            if (back_2_a) q.push_back(k);
        end
        check("midrst_pre_pulses", q.size(), 2);
        #2 rst = 1;
        #1;
        check("midrst_out_drop", {31'd0, back_2_a}, 0);
        check("midrst_held_drop", {28'd0, held_a}, 0);
        @(negedge clk);
        rst = 0;
        q.delete();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (back_2_a) q.push_back(k);
        end
        check("midrst_count", q.size(), 1);
        check("midrst_t", (q.size() > 0) ? q[0] : -1, 6);
        idle(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
